// File: rtl/uart_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pwm_pkg
// Purpose  : Shared constants and FSM state type for the UART PWM command
//            parser (frame = SYNC, CHANNEL, DUTY, CHECKSUM).
// Contents : SYNC_BYTE / ACK_BYTE / NAK_BYTE framing constants,
//            parser_state_e state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pwm_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_CHAN = 2'd1,
        S_DUTY = 2'd2,
        S_CSUM = 2'd3
    } parser_state_e;

endpackage : uart_pwm_pkg
`default_nettype wire

// File: rtl/uart_pwm_cmd_parser_timeout.sv
`default_nettype none
// ============================================================================
// Module   : uart_pwm_timeout
// Purpose  : Inter-byte watchdog. Counts clocks while enabled, clears on
//            i_Clear, and flags expiry when the count reaches TERM_COUNT-1.
//            The count saturates there, so it never wraps.
// Ports    : i_Clock   - system clock
//            i_Reset   - asynchronous, active-high reset
//            i_Clear   - synchronous clear (has priority over expiry)
//            i_Enable  - count enable
//            o_Expire  - combinational expiry flag for the current cycle
// Revision : 1.0 - initial release
// ============================================================================
module uart_pwm_timeout #(
    parameter int TERM_COUNT = 4340
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Expire
);

    localparam int              CNT_W = $clog2(TERM_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM_COUNT - 1);

    logic [CNT_W-1:0] count_q;

    // A clear in the same cycle (a byte arriving) suppresses expiry.
    assign o_Expire = i_Enable && !i_Clear && (count_q == LAST);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count_q <= '0;
        end else if (i_Clear) begin
            count_q <= '0;
        end else if (i_Enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule : uart_pwm_timeout
`default_nettype wire

// File: rtl/uart_pwm_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_pwm_cmd_parser
// Purpose  : Assembles SYNC/CHANNEL/DUTY/CHECKSUM frames from the UART RX
//            byte stream and writes per-channel 8-bit PWM duty registers.
//            Bad checksum, out-of-range channel or inter-byte timeout
//            discard the frame and pulse o_Frame_Err.
// Ports    : i_Clock, i_Reset (async, active-high)
//            i_RX_DV, i_RX_Byte            - byte stream from UART RX
//            o_Duty_Bus                    - channel n at [8n+7:8n]
//            o_Update_Strobe, o_Update_Ch  - registered write notification
//            o_Frame_Err                   - registered error pulse
//            o_Busy                        - frame in progress
// Option   : UART_PARSER_ACK_EN adds i_TX_Active, o_TX_DV, o_TX_Byte that
//            send ACK (0x06) / NAK (0x15) toward a UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_pwm_cmd_parser
    import uart_pwm_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_RX_DV,
    input  logic [7:0]                i_RX_Byte,
    output logic [8*NUM_CH-1:0]       o_Duty_Bus,
    output logic                      o_Update_Strobe,
    output logic [$clog2(NUM_CH)-1:0] o_Update_Ch,
    output logic                      o_Frame_Err,
`ifdef UART_PARSER_ACK_EN
    input  logic                      i_TX_Active,
    output logic                      o_TX_DV,
    output logic [7:0]                o_TX_Byte,
`endif
    output logic                      o_Busy
);

    localparam int         CH_W     = $clog2(NUM_CH);
    localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

    parser_state_e   state_q, state_d;
    logic [7:0]      chan_q, chan_d;
    logic [7:0]      duty_byte_q, duty_byte_d;
    logic            strobe_q, strobe_d;
    logic            err_q, err_d;
    logic [CH_W-1:0] upd_ch_q, upd_ch_d;
    logic            w_expire;
    logic            w_busy;

    assign w_busy = (state_q != S_SYNC);

    // Counter is held clear outside a frame and restarted by every byte.
    uart_pwm_timeout #(
        .TERM_COUNT (TIMEOUT_BITS * CLKS_PER_BIT)
    ) u_timeout (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Clear  (i_RX_DV || !w_busy),
        .i_Enable (w_busy),
        .o_Expire (w_expire)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= S_SYNC;
            chan_q      <= 8'h00;
            duty_byte_q <= 8'h00;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            upd_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            duty_byte_q <= duty_byte_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
            upd_ch_q    <= upd_ch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        duty_byte_d = duty_byte_q;
        strobe_d    = 1'b0;
        err_d       = 1'b0;
        upd_ch_d    = upd_ch_q;
        case (state_q)
            S_SYNC: begin
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = S_CHAN;
            end
            S_CHAN: begin
                // 0xA5 here is channel data; no resynchronisation.
                if (i_RX_DV) begin
                    chan_d  = i_RX_Byte;
                    state_d = S_DUTY;
                end
            end
            S_DUTY: begin
                if (i_RX_DV) begin
                    duty_byte_d = i_RX_Byte;
                    state_d     = S_CSUM;
                end
            end
            S_CSUM: begin
                if (i_RX_DV) begin
                    state_d = S_SYNC;
                    if ((i_RX_Byte == (SYNC_BYTE ^ chan_q ^ duty_byte_q)) &&
                        (chan_q < NUM_CH_B)) begin
                        strobe_d = 1'b1;
                        upd_ch_d = chan_q[CH_W-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
        // Expiry is already masked by a same-cycle byte inside the watchdog.
        if (w_expire) begin
            state_d = S_SYNC;
            err_d   = 1'b1;
        end
    end

    // Duty registers are written on the same edge that raises the strobe.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_duty
        logic [7:0] duty_q;
        always_ff @(posedge i_Clock or posedge i_Reset) begin
            if (i_Reset) begin
                duty_q <= 8'h00;
            end else if (strobe_d && (upd_ch_d == CH_W'(n))) begin
                duty_q <= duty_byte_q;
            end
        end
        assign o_Duty_Bus[8*n +: 8] = duty_q;
    end

    assign o_Update_Strobe = strobe_q;
    assign o_Update_Ch     = upd_ch_q;
    assign o_Frame_Err     = err_q;
    assign o_Busy          = w_busy;

`ifdef UART_PARSER_ACK_EN
    logic       tx_dv_q;
    logic [7:0] tx_byte_q;
    logic       pend_vld_q;
    logic [7:0] pend_byte_q;
    logic       w_resp_vld;
    logic [7:0] w_resp_byte;

    assign w_resp_vld  = strobe_q || err_q;
    assign w_resp_byte = strobe_q ? ACK_BYTE : NAK_BYTE;

    // A fresh response always supersedes anything still pending.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            pend_vld_q  <= 1'b0;
            pend_byte_q <= 8'h00;
        end else begin
            tx_dv_q <= 1'b0;
            if (w_resp_vld) begin
                if (!i_TX_Active) begin
                    tx_dv_q    <= 1'b1;
                    tx_byte_q  <= w_resp_byte;
                    pend_vld_q <= 1'b0;
                end else begin
                    pend_vld_q  <= 1'b1;
                    pend_byte_q <= w_resp_byte;
                end
            end else if (pend_vld_q && !i_TX_Active) begin
                tx_dv_q    <= 1'b1;
                tx_byte_q  <= pend_byte_q;
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign o_TX_DV   = tx_dv_q;
    assign o_TX_Byte = tx_byte_q;
`endif

endmodule : uart_pwm_cmd_parser
`default_nettype wire

// File: doc/uart_pwm_cmd_parser.md
Name: uart_pwm_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and upstream of the PWM generator(s).
- Consumes the receiver's byte stream (data-valid pulse plus byte) and assembles 4-byte command frames: SYNC, CHANNEL, DUTY, CHECKSUM.
- Validated frames update one per-channel 8-bit duty register; the PWM generators use these registers directly.
- Malformed, invalid or stalled frames are discarded and flagged.

Parameters:
- NUM_CH, 4, number of PWM duty channels (legal range 2..16)
- CLKS_PER_BIT, 217, UART clocks per bit, matching the receiver
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods; timeout = TIMEOUT_BITS*CLKS_PER_BIT clocks

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_RX_DV  in  1  one-cycle pulse, byte valid from UART RX
- i_RX_Byte  in  8  received byte, valid when i_RX_DV=1
- o_Duty_Bus  out  8*NUM_CH  duty registers; channel n occupies bits [8n+7:8n]
- o_Update_Strobe  out  1  one-cycle pulse when a duty register is written
- o_Update_Ch  out  clog2(NUM_CH)  channel written, valid with the strobe
- o_Frame_Err  out  1  one-cycle pulse on bad checksum, bad channel or timeout
- o_Busy  out  1  high whenever the FSM is not in S_SYNC

Behaviour:
- Interface (already decided): one clock, i_Clock; reset i_Reset is asynchronous and active-high.
- Reset values: all duty registers 0x00 (PWM off); all output strobes 0; o_Update_Ch 0; o_Busy 0; FSM in S_SYNC; timeout counter 0.
- S_SYNC:
  - DV with byte 0xA5 -> S_CHAN.
  - Any other byte is silently dropped (no error).
- S_CHAN: on DV, latch the channel byte -> S_DUTY. A 0xA5 byte here is data; there is no resync.
- S_DUTY: on DV, latch the duty byte -> S_CSUM.
- S_CSUM: on DV, compare the byte with 0xA5 ^ chan ^ duty.
  - Match and chan < NUM_CH: write the duty register; pulse o_Update_Strobe and drive o_Update_Ch.
  - Otherwise: pulse o_Frame_Err and leave the registers unchanged.
  - Always return to S_SYNC.
- Latency: the register write, strobe and error are all registered. They become visible on the clock edge after the cycle in which the CSUM-byte DV is sampled.
- Timeout:
  - The counter clears on every DV and whenever the FSM is in S_SYNC; otherwise it increments.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT-1 -> pulse o_Frame_Err and return to S_SYNC.
  - The counter width must hold the full count; it never wraps.
- Simultaneous DV and timeout expiry: the DV wins. The byte is processed normally, the counter clears, and no error is raised.
- Reset asserted mid-frame: immediate abort; duty registers return to 0x00.
- A DV arriving in the same cycle as a strobe or error output is accepted normally; there is no dead cycle between frames.

Optional Feature:
- Macro: UART_PARSER_ACK_EN.
- Defined: adds ports i_TX_Active (in, 1), o_TX_DV (out, 1) and o_TX_Byte (out, 8) toward a UART transmitter.
  - Each success queues ACK 0x06; each error, including timeout, queues NAK 0x15.
  - o_TX_DV pulses for one cycle when i_TX_Active=0, at the earliest the cycle after the strobe or error.
  - A one-entry pending slot holds the response while i_TX_Active=1; a newer response overwrites it.
  - Reset clears the pending slot.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package uart_pwm_pkg:
  - constants SYNC_BYTE=8'hA5, ACK_BYTE=8'h06, NAK_BYTE=8'h15
  - FSM state enum {S_SYNC, S_CHAN, S_DUTY, S_CSUM}
- One natural sub-module: uart_pwm_timeout.
  - Inter-byte counter with clear/enable inputs and an expiry pulse output; parameterised by its terminal count.
- The parser FSM, duty register file and ack logic stay in the top module.

Test Plan:
- Bytes A5 01 4D E9, standard 217-clock bit spacing -> ch1 duty=0x4D; one strobe with o_Update_Ch=1; other channels 0x00; no error.
- Bytes A5 03 80 27 (bad checksum, correct is 0x26) -> one o_Frame_Err pulse; ch3 stays 0x00; next frame A5 03 80 26 -> ch3=0x80.
- Bytes A5 07 10 B2 (valid checksum, channel >= NUM_CH) -> o_Frame_Err; no register changes; FSM returns to S_SYNC.
- Bytes 33 A5 02 (then silence for more than 20*217 clocks) -> no error on 0x33; o_Frame_Err exactly at expiry; o_Busy falls; next full frame accepted.
- Reset pulsed between DUTY and CSUM bytes of a frame to ch1 after ch1=0x4D was set -> ch1 reads 0x00; the trailing CSUM byte is ignored as a non-sync byte; no strobe.
- With UART_PARSER_ACK_EN and i_TX_Active held high over two frames (good, then bad) -> a single o_TX_DV carrying 0x15 after i_TX_Active drops.
